// File: rtl/writeback_unit_pkg.sv
// ============================================================================
// writeback_unit_pkg : shared ISA encodings and load-queue entry type
// Rev 1.0
// ============================================================================
`default_nettype none

package writeback_unit_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t   rd;
        logic [2:0] funct3;
        logic [1:0] offset;
    } lq_entry_t;

endpackage

`default_nettype wire

// File: rtl/writeback_unit_if.sv
// ============================================================================
// writeback_unit_if : ALU result, load issue, memory response and write-port bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface writeback_unit_if #(
    parameter int DWIDTH = 32
);
    import writeback_unit_pkg::*;

    logic              alu_valid_i;
    reg_idx_t          alu_rd_i;
    logic [DWIDTH-1:0] alu_data_i;

    logic              ld_issue_valid_i;
    logic              ld_issue_ready_o;
    reg_idx_t          ld_issue_rd_i;
    logic [2:0]        ld_issue_funct3_i;
    logic [1:0]        ld_issue_offset_i;

    logic              mem_rsp_valid_i;
    logic              mem_rsp_ready_o;
    logic [DWIDTH-1:0] mem_rsp_data_i;

    logic              regwren_o;
    reg_idx_t          rd_o;
    logic [DWIDTH-1:0] datawb_o;
    logic [31:0]       busy_o;
    logic              err_o;

    // The writeback unit itself
    modport slave (
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  ld_issue_valid_i, ld_issue_rd_i, ld_issue_funct3_i, ld_issue_offset_i,
        output ld_issue_ready_o,
        input  mem_rsp_valid_i, mem_rsp_data_i,
        output mem_rsp_ready_o,
        output regwren_o, rd_o, datawb_o, busy_o, err_o
    );

    // Pipeline / memory side
    modport master (
        output alu_valid_i, alu_rd_i, alu_data_i,
        output ld_issue_valid_i, ld_issue_rd_i, ld_issue_funct3_i, ld_issue_offset_i,
        input  ld_issue_ready_o,
        output mem_rsp_valid_i, mem_rsp_data_i,
        input  mem_rsp_ready_o,
        input  regwren_o, rd_o, datawb_o, busy_o, err_o
    );

endinterface

`default_nettype wire

// File: rtl/writeback_unit_load_align.sv
// ============================================================================
// writeback_unit_load_align : byte/halfword select and sign/zero extension
// Rev 1.0
// ============================================================================
`default_nettype none

module writeback_unit_load_align
    import writeback_unit_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [2:0]        funct3_i,
    input  logic [1:0]        offset_i,
    input  logic [DWIDTH-1:0] word_i,
    output logic [DWIDTH-1:0] data_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word_i[7:0];
        case (offset_i)
            2'd1:    w_byte = word_i[15:8];
            2'd2:    w_byte = word_i[23:16];
            2'd3:    w_byte = word_i[31:24];
            default: w_byte = word_i[7:0];
        endcase
        w_half = offset_i[1] ? word_i[31:16] : word_i[15:0];
    end

    // Unknown funct3 codes fall back to a full-word load
    always_comb begin
        data_o = word_i;
        case (funct3_i)
            F3_LB:   data_o = {{(DWIDTH-8){w_byte[7]}}, w_byte};
            F3_LH:   data_o = {{(DWIDTH-16){w_half[15]}}, w_half};
            F3_LBU:  data_o = {{(DWIDTH-8){1'b0}}, w_byte};
            F3_LHU:  data_o = {{(DWIDTH-16){1'b0}}, w_half};
            F3_LW:   data_o = word_i;
            default: data_o = word_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
// ============================================================================
// writeback_unit : register-file write-port owner merging ALU results and
//                  in-order load responses, with per-register busy scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int DWIDTH   = 32,
    parameter int LQ_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    writeback_unit_if.slave wb
);

    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(LQ_DEPTH);

    lq_entry_t         lq_mem_q [LQ_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              hold_valid_q, hold_valid_d;
    reg_idx_t          hold_rd_q, hold_rd_d;
    logic [DWIDTH-1:0] hold_data_q, hold_data_d;
    logic              err_q, err_d;

    logic              w_full, w_empty, w_push, w_rsp_acc, w_pop;
    lq_entry_t         w_head;
    logic [DWIDTH-1:0] w_rsp_data;
    logic              w_wr_valid;
    reg_idx_t          w_wr_rd;
    logic [DWIDTH-1:0] w_wr_data;
    logic [PTR_W-1:0]  w_age;
    logic [31:0]       w_busy;

    assign w_full    = (count_q == C_FULL_CNT);
    assign w_empty   = (count_q == '0);
    assign w_push    = wb.ld_issue_valid_i && !w_full;
    assign w_rsp_acc = wb.mem_rsp_valid_i && !hold_valid_q;
    assign w_pop     = w_rsp_acc && !w_empty;
    assign w_head    = lq_mem_q[rd_ptr_q];

    writeback_unit_load_align #(
        .DWIDTH (DWIDTH)
    ) u_load_align (
        .funct3_i (w_head.funct3),
        .offset_i (w_head.offset),
        .word_i   (wb.mem_rsp_data_i),
        .data_o   (w_rsp_data)
    );

    // Write-port arbitration: ALU first, then the held load, then a live response
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_rd_d    = hold_rd_q;
        hold_data_d  = hold_data_q;
        w_wr_valid   = 1'b0;
        w_wr_rd      = '0;
        w_wr_data    = '0;
        if (wb.alu_valid_i) begin
            w_wr_valid = 1'b1;
            w_wr_rd    = wb.alu_rd_i;
            w_wr_data  = wb.alu_data_i;
            if (w_pop) begin
                hold_valid_d = 1'b1;
                hold_rd_d    = w_head.rd;
                hold_data_d  = w_rsp_data;
            end
        end else if (hold_valid_q) begin
            w_wr_valid   = 1'b1;
            w_wr_rd      = hold_rd_q;
            w_wr_data    = hold_data_q;
            hold_valid_d = 1'b0;
        end else if (w_pop) begin
            w_wr_valid = 1'b1;
            w_wr_rd    = w_head.rd;
            w_wr_data  = w_rsp_data;
        end
    end

    assign wb.regwren_o        = w_wr_valid && (w_wr_rd != '0);
    assign wb.rd_o             = w_wr_rd;
    assign wb.datawb_o         = w_wr_data;
    assign wb.ld_issue_ready_o = !w_full;
    assign wb.mem_rsp_ready_o  = !hold_valid_q;
    assign wb.err_o            = err_q;

    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        err_d = err_q | (w_rsp_acc & w_empty);
    end

    // An entry is live when its distance from the read pointer is below the count
    always_comb begin
        w_busy = '0;
        w_age  = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            w_age = PTR_W'(i) - rd_ptr_q;
            if ({1'b0, w_age} < count_q) begin
                w_busy[lq_mem_q[i].rd] = 1'b1;
            end
        end
        if (hold_valid_q) begin
            w_busy[hold_rd_q] = 1'b1;
        end
        w_busy[0] = 1'b0;
    end

    assign wb.busy_o = w_busy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_rd_q    <= '0;
            hold_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hold_valid_q <= hold_valid_d;
            hold_rd_q    <= hold_rd_d;
            hold_data_q  <= hold_data_d;
            err_q        <= err_d;
        end
    end

    // Queue payload needs no reset: validity comes from count_q alone
    always_ff @(posedge clk) begin
        if (w_push) begin
            lq_mem_q[wr_ptr_q] <= {wb.ld_issue_rd_i, wb.ld_issue_funct3_i, wb.ld_issue_offset_i};
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
// tb_writeback_unit : directed scenarios plus randomized traffic against a
//                     queue-based reference model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_writeback_unit;
    import writeback_unit_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_unit_if #(.DWIDTH(DW)) bus();

    writeback_unit #(.DWIDTH(DW), .LQ_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] off;
    } ld_t;

    ld_t         mq[$];
    logic        m_hold_v;
    logic [4:0]  m_hold_rd;
    logic [31:0] m_hold_data;
    logic        m_err;

    logic        e_wren, e_ldrdy, e_rsprdy, e_err;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_busy;

    function automatic logic [31:0] ref_fmt(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            3'b000: begin v = (w >> (8 * off)) & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
            3'b100:       v = (w >> (8 * off)) & 32'hFF;
            3'b001: begin v = (w >> (16 * off[1])) & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
            3'b101:       v = (w >> (16 * off[1])) & 32'hFFFF;
            default:      v = w;
        endcase
        return v;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_hold_v    = 1'b0;
        m_hold_rd   = '0;
        m_hold_data = '0;
        m_err       = 1'b0;
    endfunction

    function automatic void model_expect();
        logic acc;
        acc      = bus.mem_rsp_valid_i && !m_hold_v;
        e_wren   = 1'b0;
        e_rd     = '0;
        e_data   = '0;
        if (bus.alu_valid_i) begin
            e_rd = bus.alu_rd_i;  e_data = bus.alu_data_i;  e_wren = (e_rd != 0);
        end else if (m_hold_v) begin
            e_rd = m_hold_rd;     e_data = m_hold_data;     e_wren = (e_rd != 0);
        end else if (acc && mq.size() > 0) begin
            e_rd   = mq[0].rd;
            e_data = ref_fmt(mq[0].f3, mq[0].off, bus.mem_rsp_data_i);
            e_wren = (e_rd != 0);
        end
        e_ldrdy  = (mq.size() < DEPTH);
        e_rsprdy = !m_hold_v;
        e_err    = m_err;
        e_busy   = '0;
        foreach (mq[i]) e_busy[mq[i].rd] = 1'b1;
        if (m_hold_v) e_busy[m_hold_rd] = 1'b1;
        e_busy[0] = 1'b0;
    endfunction

    function automatic void model_commit();
        logic acc, nonempty, can_push;
        ld_t  head, nw;
        acc      = bus.mem_rsp_valid_i && !m_hold_v;
        nonempty = (mq.size() > 0);
        can_push = (mq.size() < DEPTH);
        head     = '{rd: 5'd0, f3: 3'd0, off: 2'd0};
        if (acc && nonempty) head = mq.pop_front();
        if (bus.alu_valid_i) begin
            if (acc && nonempty) begin
                m_hold_v    = 1'b1;
                m_hold_rd   = head.rd;
                m_hold_data = ref_fmt(head.f3, head.off, bus.mem_rsp_data_i);
            end
        end else if (m_hold_v) begin
            m_hold_v = 1'b0;
        end
        if (acc && !nonempty) m_err = 1'b1;
        if (bus.ld_issue_valid_i && can_push) begin
            nw = '{rd: bus.ld_issue_rd_i, f3: bus.ld_issue_funct3_i, off: bus.ld_issue_offset_i};
            mq.push_back(nw);
        end
    endfunction

    task automatic idle();
        bus.alu_valid_i       = 1'b0;
        bus.alu_rd_i          = '0;
        bus.alu_data_i        = '0;
        bus.ld_issue_valid_i  = 1'b0;
        bus.ld_issue_rd_i     = '0;
        bus.ld_issue_funct3_i = '0;
        bus.ld_issue_offset_i = '0;
        bus.mem_rsp_valid_i   = 1'b0;
        bus.mem_rsp_data_i    = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
        bus.ld_issue_valid_i  = 1'b1;
        bus.ld_issue_rd_i     = rd;
        bus.ld_issue_funct3_i = f3;
        bus.ld_issue_offset_i = off;
    endtask

    task automatic respond(input logic [31:0] word);
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_data_i  = word;
    endtask

    task automatic tick();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        #1 rst = 1'b0;
        #1;
        model_reset();
        checks++; if (bus.regwren_o !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", bus.regwren_o); end
        checks++; if (bus.rd_o !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", bus.rd_o); end
        checks++; if (bus.datawb_o !== 32'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.datawb_o); end
        checks++; if (bus.busy_o !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h expected 0", bus.busy_o); end
        checks++; if (bus.ld_issue_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ldrdy: got %b expected 1", bus.ld_issue_ready_o); end
        checks++; if (bus.mem_rsp_ready_o !== 1'b1) begin errors++; $display("FAIL reset_rsprdy: got %b expected 1", bus.mem_rsp_ready_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", bus.err_o); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_single_lb();
        issue(5'd5, F3_LB, 2'd3);
        tick();
        idle();
        #1;
        checks++; if (bus.busy_o[5] !== 1'b1) begin errors++; $display("FAIL lb_busy_before: got %b expected 1", bus.busy_o[5]); end
        respond(32'h80FF_FF12);
        #1;
        checks++; if (bus.regwren_o !== 1'b1) begin errors++; $display("FAIL lb_wren: got %b expected 1", bus.regwren_o); end
        checks++; if (bus.rd_o !== 5'd5) begin errors++; $display("FAIL lb_rd: got %0d expected 5", bus.rd_o); end
        checks++; if (bus.datawb_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", bus.datawb_o); end
        tick();
        idle();
        #1;
        checks++; if (bus.busy_o[5] !== 1'b0) begin errors++; $display("FAIL lb_busy_after: got %b expected 0", bus.busy_o[5]); end
    endtask

    task automatic test_collision();
        issue(5'd8, F3_LHU, 2'd2);
        tick();
        idle();
        bus.alu_valid_i = 1'b1;
        bus.alu_rd_i    = 5'd7;
        bus.alu_data_i  = 32'h11;
        respond(32'hBEEF_0000);
        #1;
        checks++; if (bus.regwren_o !== 1'b1 || bus.rd_o !== 5'd7 || bus.datawb_o !== 32'h11)
            begin errors++; $display("FAIL coll_alu: got wren=%b rd=%0d data=%h expected 1/7/00000011", bus.regwren_o, bus.rd_o, bus.datawb_o); end
        tick();
        idle();
        #1;
        checks++; if (bus.regwren_o !== 1'b1 || bus.rd_o !== 5'd8 || bus.datawb_o !== 32'h0000_BEEF)
            begin errors++; $display("FAIL coll_hold: got wren=%b rd=%0d data=%h expected 1/8/0000beef", bus.regwren_o, bus.rd_o, bus.datawb_o); end
        checks++; if (bus.mem_rsp_ready_o !== 1'b0) begin errors++; $display("FAIL coll_rsprdy: got %b expected 0", bus.mem_rsp_ready_o); end
        tick();
        checks++; if (bus.busy_o[8] !== 1'b0) begin errors++; $display("FAIL coll_busy: got %b expected 0", bus.busy_o[8]); end
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) begin
            issue(5'(10 + i), F3_LW, 2'd0);
            tick();
        end
        idle();
        #1;
        checks++; if (bus.ld_issue_ready_o !== 1'b0) begin errors++; $display("FAIL full_ldrdy: got %b expected 0", bus.ld_issue_ready_o); end
        issue(5'd20, F3_LW, 2'd0);
        respond(32'hA0);
        #1;
        checks++; if (bus.rd_o !== 5'd10 || bus.datawb_o !== 32'hA0)
            begin errors++; $display("FAIL full_rsp0: got rd=%0d data=%h expected 10/000000a0", bus.rd_o, bus.datawb_o); end
        tick();
        idle();
        #1;
        checks++; if (bus.ld_issue_ready_o !== 1'b1) begin errors++; $display("FAIL full_ldrdy_after: got %b expected 1", bus.ld_issue_ready_o); end
        for (int i = 1; i < DEPTH; i++) begin
            respond(32'hA0 + 32'(i));
            #1;
            checks++; if (bus.regwren_o !== 1'b1 || bus.rd_o !== 5'(10 + i) || bus.datawb_o !== 32'hA0 + 32'(i))
                begin errors++; $display("FAIL full_rsp%0d: got wren=%b rd=%0d data=%h expected 1/%0d/%h", i, bus.regwren_o, bus.rd_o, bus.datawb_o, 10 + i, 32'hA0 + 32'(i)); end
            tick();
            idle();
        end
        #1;
        checks++; if (bus.busy_o !== 32'd0) begin errors++; $display("FAIL full_drained_busy: got %h expected 0", bus.busy_o); end
    endtask

    task automatic test_dup_and_x0();
        issue(5'd9, F3_LW, 2'd0); tick();
        issue(5'd9, F3_LW, 2'd0); tick();
        issue(5'd0, F3_LW, 2'd0); tick();
        idle();
        #1;
        checks++; if (bus.busy_o[9] !== 1'b1) begin errors++; $display("FAIL dup_busy0: got %b expected 1", bus.busy_o[9]); end
        respond(32'h1234);
        #1;
        checks++; if (bus.regwren_o !== 1'b1 || bus.rd_o !== 5'd9) begin errors++; $display("FAIL dup_wb1: got wren=%b rd=%0d expected 1/9", bus.regwren_o, bus.rd_o); end
        tick(); idle(); #1;
        checks++; if (bus.busy_o[9] !== 1'b1) begin errors++; $display("FAIL dup_busy1: got %b expected 1", bus.busy_o[9]); end
        respond(32'h5678);
        #1;
        checks++; if (bus.datawb_o !== 32'h5678) begin errors++; $display("FAIL dup_wb2: got %h expected 00005678", bus.datawb_o); end
        tick(); idle(); #1;
        checks++; if (bus.busy_o[9] !== 1'b0) begin errors++; $display("FAIL dup_busy2: got %b expected 0", bus.busy_o[9]); end
        respond(32'h9);
        #1;
        checks++; if (bus.regwren_o !== 1'b0) begin errors++; $display("FAIL x0_wren: got %b expected 0", bus.regwren_o); end
        tick(); idle(); #1;
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL x0_err: got %b expected 0", bus.err_o); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            idle();
            if ($urandom_range(0, 99) < 30) begin
                bus.alu_valid_i = 1'b1;
                bus.alu_rd_i    = 5'($urandom_range(0, 7));
                bus.alu_data_i  = $urandom;
            end
            if ($urandom_range(0, 99) < 45)
                issue(5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
            if (mq.size() > 0 && $urandom_range(0, 99) < 50)
                respond($urandom);
            #1;
            model_expect();
            checks++; if (bus.regwren_o !== e_wren) begin errors++; $display("FAIL rand_wren c%0d: got %b expected %b", c, bus.regwren_o, e_wren); end
            if (e_wren) begin
                checks++; if (bus.rd_o !== e_rd) begin errors++; $display("FAIL rand_rd c%0d: got %0d expected %0d", c, bus.rd_o, e_rd); end
                checks++; if (bus.datawb_o !== e_data) begin errors++; $display("FAIL rand_data c%0d: got %h expected %h", c, bus.datawb_o, e_data); end
            end
            checks++; if (bus.busy_o !== e_busy) begin errors++; $display("FAIL rand_busy c%0d: got %h expected %h", c, bus.busy_o, e_busy); end
            checks++; if (bus.ld_issue_ready_o !== e_ldrdy) begin errors++; $display("FAIL rand_ldrdy c%0d: got %b expected %b", c, bus.ld_issue_ready_o, e_ldrdy); end
            checks++; if (bus.mem_rsp_ready_o !== e_rsprdy) begin errors++; $display("FAIL rand_rsprdy c%0d: got %b expected %b", c, bus.mem_rsp_ready_o, e_rsprdy); end
            checks++; if (bus.err_o !== e_err) begin errors++; $display("FAIL rand_err c%0d: got %b expected %b", c, bus.err_o, e_err); end
            tick();
        end
        // Drain remaining loads so later scenarios start with an empty queue
        for (int c = 0; c < 3 * DEPTH; c++) begin
            idle();
            if (mq.size() == 0 && !m_hold_v) break;
            if (mq.size() > 0) respond($urandom);
            #1;
            model_expect();
            checks++; if (bus.regwren_o !== e_wren || (e_wren && (bus.rd_o !== e_rd || bus.datawb_o !== e_data)))
                begin errors++; $display("FAIL drain_wb d%0d: got %b/%0d/%h expected %b/%0d/%h", c, bus.regwren_o, bus.rd_o, bus.datawb_o, e_wren, e_rd, e_data); end
            tick();
        end
        idle();
        #1;
        checks++; if (bus.busy_o !== 32'd0 || mq.size() != 0 || m_hold_v)
            begin errors++; $display("FAIL drain_done: busy=%h model_q=%0d model_hold=%b expected all clear", bus.busy_o, mq.size(), m_hold_v); end
    endtask

    task automatic test_err();
        idle();
        respond(32'hDEAD_BEEF);
        #1;
        checks++; if (bus.regwren_o !== 1'b0) begin errors++; $display("FAIL err_wren: got %b expected 0", bus.regwren_o); end
        tick(); idle(); #1;
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", bus.err_o); end
        repeat (3) tick();
        checks++; if (bus.err_o !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", bus.err_o); end
    endtask

    task automatic test_reset_mid();
        issue(5'd1, F3_LW, 2'd0); tick();
        issue(5'd2, F3_LB, 2'd1); tick();
        issue(5'd3, F3_LH, 2'd2); tick();
        idle();
        #1;
        checks++; if (bus.busy_o !== 32'h0000_000E) begin errors++; $display("FAIL mid_busy_pre: got %h expected 0000000e", bus.busy_o); end
        rst = 1'b0;
        #1;
        model_reset();
        checks++; if (bus.busy_o !== 32'd0) begin errors++; $display("FAIL mid_busy: got %h expected 0", bus.busy_o); end
        checks++; if (bus.ld_issue_ready_o !== 1'b1) begin errors++; $display("FAIL mid_ldrdy: got %b expected 1", bus.ld_issue_ready_o); end
        checks++; if (bus.regwren_o !== 1'b0) begin errors++; $display("FAIL mid_wren: got %b expected 0", bus.regwren_o); end
        checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", bus.err_o); end
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        checks++; if (bus.busy_o !== 32'd0 || bus.mem_rsp_ready_o !== 1'b1)
            begin errors++; $display("FAIL mid_after: busy=%h rsprdy=%b expected 0/1", bus.busy_o, bus.mem_rsp_ready_o); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        model_reset();
        test_reset();
        test_single_lb();
        test_collision();
        test_full();
        test_dup_and_x0();
        test_random();
        test_err();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
